// File: rtl/pzbcm_sram_read_buffer.sv
`timescale 1ns/1ps
// Read front end for a banked fixed-latency SRAM: issues bank strobes, tracks in-flight reads
// and captures returned data into a credit-protected response FIFO.
module pzbcm_sram_read_buffer #(
   parameter int WORDS        = 1024,
   parameter int DATA_WIDTH   = 32,
   parameter int BANKS        = 1,
   parameter int BANK_LSB     = 0,
   parameter int READ_LATENCY = 1,
   parameter int DEPTH        = READ_LATENCY + 1,
   localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1,
   localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int PW = ((WORDS / BANKS) > 1) ? $clog2(WORDS / BANKS) : 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_req_valid,
   output logic                        o_req_ready,
   input  logic [AW-1:0]               i_req_address,
   output logic [BANKS-1:0]            o_sram_read,
   output logic [PW-1:0]               o_sram_address,
   input  logic [BANKS*DATA_WIDTH-1:0] i_sram_rdata,
   output logic                        o_rsp_valid,
   input  logic                        i_rsp_ready,
   output logic [DATA_WIDTH-1:0]       o_rsp_data,
   output logic                        o_busy
);

   localparam int CW   = $clog2(DEPTH + 1);
   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [BW-1:0]           req_bank;
   logic [PW-1:0]           req_ptr;
   logic                    accept;
   logic                    pop;
   logic                    fifo_write;
   logic [DATA_WIDTH-1:0]   fifo_wdata;

   logic [CW-1:0]           count_q, count_d;
   logic [CW-1:0]           fill_q, fill_d;
   logic [PTRW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
   logic [BW-1:0]           pipe_bank_q [READ_LATENCY];
   logic [BW-1:0]           pipe_bank_d [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
   endfunction

   if (BANKS == 1) begin : g_single_bank
      assign req_bank = '0;
      assign req_ptr  = i_req_address[PW-1:0];
   end else if (BANK_LSB != 0) begin : g_bank_lsb
      assign req_bank = i_req_address[BW-1:0];
      assign req_ptr  = i_req_address[BW +: PW];
   end else begin : g_bank_msb
      assign req_bank = i_req_address[AW-1 -: BW];
      assign req_ptr  = i_req_address[PW-1:0];
   end

   // Credits cover every read from strobe to pop, so a FIFO write always finds a free slot.
   assign o_req_ready    = (count_q < CW'(DEPTH));
   assign accept         = i_req_valid & o_req_ready & i_rst_n;
   assign o_sram_address = req_ptr;
   assign o_rsp_valid    = (fill_q != '0);
   assign o_rsp_data     = mem_q[rd_ptr_q];
   assign pop            = o_rsp_valid & i_rsp_ready;
   assign o_busy         = (count_q != '0);
   assign fifo_write     = pipe_valid_q[READ_LATENCY-1];

   // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      o_sram_read = '0;
      for (int b = 0; b < BANKS; b++) begin
         o_sram_read[b] = accept && (req_bank == BW'(b));
      end
   end

   always_comb begin
      fifo_wdata = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (pipe_bank_q[READ_LATENCY-1] == BW'(b)) begin
            fifo_wdata = i_sram_rdata[b*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      pipe_valid_d    = pipe_valid_q;
      pipe_bank_d     = pipe_bank_q;
      pipe_valid_d[0] = accept;
      pipe_bank_d[0]  = req_bank;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
         pipe_bank_d[i]  = pipe_bank_q[i-1];
      end

      count_d = count_q;
      if (accept && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!accept && pop) begin
         count_d = count_q - CW'(1);
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (fifo_write) begin
         mem_d[wr_ptr_q] = fifo_wdata;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (fifo_write && !pop) begin
         fill_d = fill_q + CW'(1);
      end else if (!fifo_write && pop) begin
         fill_d = fill_q - CW'(1);
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q      <= '0;
         fill_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         pipe_valid_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_bank_q[i] <= '0;
         end
         // NOTE: storage is reset because o_rsp_data shows the head entry directly and must read 0 out of reset.
         for (int d = 0; d < DEPTH; d++) begin
            mem_q[d] <= '0;
         end
      end else begin
         count_q      <= count_d;
         fill_q       <= fill_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_bank_q  <= pipe_bank_d;
         mem_q        <= mem_d;
      end
   end

   fifo_no_overflow_a: assert property (
      @(posedge i_clk) disable iff (!i_rst_n) fifo_write |-> (fill_q < CW'(DEPTH))
   );

endmodule

// File: tb/tb_pzbcm_sram_read_buffer.sv
`timescale 1ns/1ps
// Bench for pzbcm_sram_read_buffer: an SRAM model feeds two instances (interleaved and MSB bank
// select) while a transaction-level credit/latency model checks every cycle of the interleaved one.
module tb_pzbcm_sram_read_buffer;

   localparam int WORDS = 16;
   localparam int DW    = 16;
   localparam int BANKS = 4;
   localparam int RL    = 2;
   localparam int DEPTH = 3;
   localparam int PWORDS = WORDS / BANKS;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_req_valid;
   logic [3:0]        i_req_address;
   logic              i_rsp_ready;
   logic [BANKS*DW-1:0] i_sram_rdata;
   logic [BANKS*DW-1:0] i_sram_rdata_m;

   logic              o_req_ready,    o_req_ready_m;
   logic [BANKS-1:0]  o_sram_read,    o_sram_read_m;
   logic [1:0]        o_sram_address, o_sram_address_m;
   logic              o_rsp_valid,    o_rsp_valid_m;
   logic [DW-1:0]     o_rsp_data,     o_rsp_data_m;
   logic              o_busy,         o_busy_m;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ref_mem [WORDS];

   typedef struct {
      logic [DW-1:0] data;
      int            avail;
   } rsp_t;
   rsp_t model_q[$];

   typedef struct packed {
      logic [BANKS-1:0] rd;
      logic [1:0]       ptr;
   } sram_cmd_t;
   sram_cmd_t hist [RL+1];

   pzbcm_sram_read_buffer #(
      .WORDS(WORDS), .DATA_WIDTH(DW), .BANKS(BANKS), .BANK_LSB(1), .READ_LATENCY(RL), .DEPTH(DEPTH)
   ) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_address(i_req_address),
      .o_sram_read(o_sram_read), .o_sram_address(o_sram_address), .i_sram_rdata(i_sram_rdata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
      .o_busy(o_busy)
   );

   pzbcm_sram_read_buffer #(
      .WORDS(WORDS), .DATA_WIDTH(DW), .BANKS(BANKS), .BANK_LSB(0), .READ_LATENCY(RL), .DEPTH(DEPTH)
   ) u_dut_msb (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready_m), .i_req_address(i_req_address),
      .o_sram_read(o_sram_read_m), .o_sram_address(o_sram_address_m), .i_sram_rdata(i_sram_rdata_m),
      .o_rsp_valid(o_rsp_valid_m), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data_m),
      .o_busy(o_busy_m)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // SRAM model: a strobe on bank b at pointer p returns word p*BANKS+b RL cycles later.
   initial begin : sram_model
      for (int k = 0; k <= RL; k++) hist[k] = '0;
      i_sram_rdata   = '0;
      i_sram_rdata_m = '0;
      forever begin
         @(negedge i_clk);
         for (int k = RL; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = {o_sram_read, o_sram_address};
         for (int b = 0; b < BANKS; b++) begin
            if (hist[RL].rd[b]) i_sram_rdata[b*DW +: DW] = ref_mem[int'(hist[RL].ptr) * BANKS + b];
            else                i_sram_rdata[b*DW +: DW] = DW'($urandom);
         end
         i_sram_rdata_m = {$urandom, $urandom};
      end
   end

   // Reference model: outstanding reads are a queue; each becomes presentable RL+1 cycles after
   // acceptance, and a request is accepted only while fewer than DEPTH reads are outstanding.
   initial begin : monitor
      int cyc;
      int a;
      logic exp_valid, exp_ready;
      logic [BANKS-1:0] exp_rd, exp_rd_m;
      cyc = 0;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) model_q.delete();
         exp_valid = (model_q.size() > 0) && (model_q[0].avail <= cyc);
         exp_ready = (model_q.size() < DEPTH);
         a         = int'(i_req_address);
         exp_rd    = (i_rst_n && i_req_valid && exp_ready) ? BANKS'(1 << (a % BANKS)) : '0;
         exp_rd_m  = (i_rst_n && i_req_valid && exp_ready) ? BANKS'(1 << (a / PWORDS)) : '0;

         checks++;
         if (o_req_ready !== exp_ready) begin
            errors++; $display("FAIL mon_req_ready cyc %0d: got %b expected %b", cyc, o_req_ready, exp_ready);
         end
         checks++;
         if (o_rsp_valid !== exp_valid) begin
            errors++; $display("FAIL mon_rsp_valid cyc %0d: got %b expected %b", cyc, o_rsp_valid, exp_valid);
         end
         checks++;
         if (o_busy !== (model_q.size() != 0)) begin
            errors++; $display("FAIL mon_busy cyc %0d: got %b expected %b", cyc, o_busy, model_q.size() != 0);
         end
         if (exp_valid) begin
            checks++;
            if (o_rsp_data !== model_q[0].data) begin
               errors++; $display("FAIL mon_rsp_data cyc %0d: got %h expected %h", cyc, o_rsp_data, model_q[0].data);
            end
         end
         checks++;
         if (o_sram_read !== exp_rd || o_sram_address !== 2'(a / BANKS)) begin
            errors++; $display("FAIL mon_lsb_issue cyc %0d: got %b/%0d expected %b/%0d",
                               cyc, o_sram_read, o_sram_address, exp_rd, a / BANKS);
         end
         checks++;
         if (o_sram_read_m !== exp_rd_m || o_sram_address_m !== 2'(a % PWORDS)) begin
            errors++; $display("FAIL mon_msb_issue cyc %0d: got %b/%0d expected %b/%0d",
                               cyc, o_sram_read_m, o_sram_address_m, exp_rd_m, a % PWORDS);
         end

         if (i_rst_n) begin
            if (exp_valid && i_rsp_ready) void'(model_q.pop_front());
            if (i_req_valid && exp_ready) model_q.push_back('{ref_mem[a], cyc + RL + 1});
         end
         cyc++;
      end
   end

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      while (o_busy && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++; $display("FAIL %s_idle: busy still %b after %0d cycles, expected 0", tag, o_busy, n);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      checks += 6;
      if (o_req_ready !== 1'b1)   begin errors++; $display("FAIL reset_req_ready: got %b expected 1", o_req_ready); end
      if (o_sram_read !== '0)     begin errors++; $display("FAIL reset_sram_read: got %b expected 0", o_sram_read); end
      if (o_sram_address !== '0)  begin errors++; $display("FAIL reset_sram_address: got %0d expected 0", o_sram_address); end
      if (o_rsp_valid !== 1'b0)   begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", o_rsp_valid); end
      if (o_rsp_data !== '0)      begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", o_rsp_data); end
      if (o_busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   // Address 6 lands on bank 2 / pointer 1 interleaved and bank 1 / pointer 2 with MSB select.
   task automatic test_single_read();
      i_req_valid   = 1'b1;
      i_req_address = 4'd6;
      i_rsp_ready   = 1'b1;
      @(negedge i_clk);
      checks += 4;
      if (o_sram_read !== 4'b0100)    begin errors++; $display("FAIL single_lsb_read: got %b expected 0100", o_sram_read); end
      if (o_sram_address !== 2'd1)    begin errors++; $display("FAIL single_lsb_addr: got %0d expected 1", o_sram_address); end
      if (o_sram_read_m !== 4'b0010)  begin errors++; $display("FAIL single_msb_read: got %b expected 0010", o_sram_read_m); end
      if (o_sram_address_m !== 2'd2)  begin errors++; $display("FAIL single_msb_addr: got %0d expected 2", o_sram_address_m); end
      next_cycle();
      i_req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge i_clk);
         checks++;
         if (o_rsp_valid !== (c == 3)) begin
            errors++; $display("FAIL single_valid cycle %0d: got %b expected %b", c, o_rsp_valid, c == 3);
         end
         if (c == 3) begin
            checks++;
            if (o_rsp_data !== 16'h00A5) begin
               errors++; $display("FAIL single_data: got %h expected 00a5", o_rsp_data);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_address_split();
      int a;
      for (int i = 0; i < 6; i++) begin
         i_req_address = 4'($urandom);
         a             = int'(i_req_address);
         i_req_valid   = 1'b1;
         i_rsp_ready   = 1'b1;
         @(negedge i_clk);
         checks += 2;
         if (o_sram_read !== BANKS'(1 << (a % BANKS)) || o_sram_address !== 2'(a / BANKS)) begin
            errors++; $display("FAIL split_lsb addr %0d: got %b/%0d", a, o_sram_read, o_sram_address);
         end
         if (o_sram_read_m !== BANKS'(1 << (a / PWORDS)) || o_sram_address_m !== 2'(a % PWORDS)) begin
            errors++; $display("FAIL split_msb addr %0d: got %b/%0d", a, o_sram_read_m, o_sram_address_m);
         end
         next_cycle();
         wait_idle("split");
      end
   endtask

   // Three reads are outstanding before the first can pop, so the registered ready may dip while
   // the stream continues; responses must still come back complete and in address order.
   task automatic test_back_to_back();
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      i_rsp_ready = 1'b1;
      while ((sent < 8 || got < 8) && cyc < 60) begin
         i_req_valid   = (sent < 8);
         i_req_address = 4'(sent);
         @(negedge i_clk);
         if (cyc < 3) begin
            checks++;
            if (o_req_ready !== 1'b1) begin
               errors++; $display("FAIL b2b_ready cycle %0d: got %b expected 1", cyc, o_req_ready);
            end
         end
         if (o_rsp_valid) begin
            if (got == 0) begin
               checks++;
               if (cyc != 3) begin
                  errors++; $display("FAIL b2b_first_latency: got cycle %0d expected 3", cyc);
               end
            end
            checks++;
            if (o_rsp_data !== ref_mem[got]) begin
               errors++; $display("FAIL b2b_data #%0d: got %h expected %h", got, o_rsp_data, ref_mem[got]);
            end
            got++;
         end
         if (i_req_valid && o_req_ready) sent++;
         next_cycle();
         cyc++;
      end
      checks++;
      if (got != 8) begin
         errors++; $display("FAIL b2b_count: got %0d responses expected 8", got);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] addrs[$];
      i_rsp_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         i_req_valid   = 1'b1;
         i_req_address = 4'($urandom);
         @(negedge i_clk);
         if (o_req_ready) addrs.push_back(i_req_address);
         next_cycle();
      end
      @(negedge i_clk);
      checks += 2;
      if (addrs.size() != DEPTH) begin
         errors++; $display("FAIL bp_accepted: got %0d expected %0d", addrs.size(), DEPTH);
      end
      if (o_req_ready !== 1'b0) begin
         errors++; $display("FAIL bp_ready_low: got %b expected 0", o_req_ready);
      end
      next_cycle();
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge i_clk);
         checks += 2;
         if (o_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_drain_valid #%0d: got %b expected 1", k, o_rsp_valid);
         end
         if (k < addrs.size() && o_rsp_data !== ref_mem[addrs[k]]) begin
            errors++; $display("FAIL bp_drain_data #%0d: got %h expected %h", k, o_rsp_data, ref_mem[addrs[k]]);
         end
         if (k == 1) begin
            checks++;
            if (o_req_ready !== 1'b1) begin
               errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", o_req_ready);
            end
         end
         next_cycle();
      end
      @(negedge i_clk);
      checks++;
      if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
         errors++; $display("FAIL bp_empty: got valid %b busy %b expected 0 0", o_rsp_valid, o_busy);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      i_rsp_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         i_req_valid   = (c != 1);
         i_req_address = 4'($urandom);
         next_cycle();
      end
      checks++;
      if (o_rsp_valid !== 1'b1 || o_busy !== 1'b1) begin
         errors++; $display("FAIL rmid_loaded: got valid %b busy %b expected 1 1", o_rsp_valid, o_busy);
      end
      i_req_valid   = 1'b1;
      i_req_address = 4'd0;
      #1;
      i_rst_n = 1'b0;
      #1;
      checks += 6;
      if (o_req_ready !== 1'b1)   begin errors++; $display("FAIL rmid_req_ready: got %b expected 1", o_req_ready); end
      if (o_sram_read !== '0)     begin errors++; $display("FAIL rmid_sram_read: got %b expected 0", o_sram_read); end
      if (o_sram_address !== '0)  begin errors++; $display("FAIL rmid_sram_address: got %0d expected 0", o_sram_address); end
      if (o_rsp_valid !== 1'b0)   begin errors++; $display("FAIL rmid_rsp_valid: got %b expected 0", o_rsp_valid); end
      if (o_rsp_data !== '0)      begin errors++; $display("FAIL rmid_rsp_data: got %h expected 0", o_rsp_data); end
      if (o_busy !== 1'b0)        begin errors++; $display("FAIL rmid_busy: got %b expected 0", o_busy); end
      i_req_valid = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst_n     = 1'b1;
      i_rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         checks++;
         if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rmid_stale cycle %0d: got valid %b busy %b expected 0 0", c, o_rsp_valid, o_busy);
         end
         next_cycle();
      end
   endtask

   task automatic test_random();
      int acc = 0;
      int n   = 0;
      while (acc < 1000 && n < 20000) begin
         i_req_valid   = ($urandom_range(0, 3) != 0);
         i_req_address = 4'($urandom);
         i_rsp_ready   = $urandom_range(0, 1) != 0;
         @(negedge i_clk);
         if (i_req_valid && o_req_ready) acc++;
         next_cycle();
         n++;
      end
      checks++;
      if (acc != 1000) begin
         errors++; $display("FAIL random_progress: got %0d accepted expected 1000", acc);
      end
   endtask

   initial begin : main
      for (int w = 0; w < WORDS; w++) ref_mem[w] = DW'($urandom);
      ref_mem[6]    = 16'h00A5;
      i_rst_n       = 1'b0;
      i_req_valid   = 1'b0;
      i_req_address = '0;
      i_rsp_ready   = 1'b0;

      test_reset();
      test_single_read();
      wait_idle("single");
      test_address_split();
      test_back_to_back();
      wait_idle("b2b");
      test_backpressure();
      wait_idle("bp");
      test_reset_mid();
      test_random();
      wait_idle("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
